// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MIPS write-back stage with variable-latency load completion
//
// Retires ALU results straight to the register file one cycle after accept, and
// parks loads in WAIT_LD until the data memory answers, then aligns and extends
// the big-endian response word. While a load is outstanding its destination is
// published on pend_valid/pend_addr so ID can stall dependent instructions.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready         MEM-stage handshake; accept = in_valid && in_ready
//   in_wd, in_wreg, in_wdata  destination, write flag and ALU/move result
//   in_is_load, in_ld_type,   load flag, type (0 LB, 1 LBU, 2 LH, 3 LHU, else LW)
//   in_addr_lo                and effective address bits [1:0]
//   dmem_rvalid, dmem_rdata   load response (big-endian word)
//   flush                     abandon an outstanding load, block accept
//   we, rw, wdata             registered regfile write port
//   pend_valid, pend_addr     outstanding load destination
//   align_err, ld_timeout     one-cycle event pulses
//   retired                   retired-instruction counter (wraps)

module wb_stage #(
    parameter int LD_TIMEOUT = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_wd,
    input  logic             in_wreg,
    input  logic [31:0]      in_wdata,
    input  logic             in_is_load,
    input  logic [2:0]       in_ld_type,
    input  logic [1:0]       in_addr_lo,
    input  logic             dmem_rvalid,
    input  logic [31:0]      dmem_rdata,
    input  logic             flush,
    output logic             we,
    output logic [4:0]       rw,
    output logic [31:0]      wdata,
    output logic             pend_valid,
    output logic [4:0]       pend_addr,
    output logic             align_err,
    output logic             ld_timeout,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_LD = 1'b1
    } state_t;

    localparam logic [2:0] LD_LB  = 3'd0;
    localparam logic [2:0] LD_LBU = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LHU = 3'd3;

    localparam logic [7:0] TIMER_LAST = 8'(LD_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic [4:0]       rw_q, rw_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             pend_valid_q, pend_valid_d;
    logic [4:0]       pend_addr_q, pend_addr_d;
    logic             align_err_q, align_err_d;
    logic             ld_timeout_q, ld_timeout_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             discard_q, discard_d;
    logic [7:0]       timer_q, timer_d;
    logic [4:0]       ld_wd_q, ld_wd_d;
    logic             ld_wreg_q, ld_wreg_d;
    logic [2:0]       ld_type_q, ld_type_d;
    logic [1:0]       ld_addr_q, ld_addr_d;

    logic             accept;
    logic             misaligned;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_value;

    assign in_ready = (state_q == IDLE) && !flush;
    assign accept   = in_valid && in_ready;

    // Alignment rule for the incoming load: bytes never fault, halves need an
    // even address, words (and unknown type codes) need a word address.
    always_comb begin
        misaligned = 1'b0;
        case (in_ld_type)
            LD_LB, LD_LBU: misaligned = 1'b0;
            LD_LH, LD_LHU: misaligned = in_addr_lo[0];
            default:       misaligned = (in_addr_lo != 2'd0);
        endcase
    end

    // Big-endian lane select: address 0 lives in the most significant byte.
    always_comb begin
        ld_byte = 8'd0;
        case (ld_addr_q)
            2'd0: ld_byte = dmem_rdata[31:24];
            2'd1: ld_byte = dmem_rdata[23:16];
            2'd2: ld_byte = dmem_rdata[15:8];
            2'd3: ld_byte = dmem_rdata[7:0];
            default: ld_byte = 8'd0;
        endcase
        ld_half = ld_addr_q[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
    end

    always_comb begin
        ld_value = dmem_rdata;
        case (ld_type_q)
            LD_LB:   ld_value = {{24{ld_byte[7]}}, ld_byte};
            LD_LBU:  ld_value = {24'd0, ld_byte};
            LD_LH:   ld_value = {{16{ld_half[15]}}, ld_half};
            LD_LHU:  ld_value = {16'd0, ld_half};
            default: ld_value = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = 1'b0;
        rw_d         = rw_q;
        wdata_d      = wdata_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        align_err_d  = 1'b0;
        ld_timeout_d = 1'b0;
        retired_d    = retired_q;
        discard_d    = discard_q;
        timer_d      = timer_q;
        ld_wd_d      = ld_wd_q;
        ld_wreg_d    = ld_wreg_q;
        ld_type_d    = ld_type_q;
        ld_addr_d    = ld_addr_q;

        case (state_q)
            IDLE: begin
                // A response that belongs to an abandoned load may still arrive
                // late; swallow exactly one of them.
                if (dmem_rvalid && discard_q) begin
                    discard_d = 1'b0;
                end
                if (accept) begin
                    if (!in_is_load) begin
                        we_d      = in_wreg && (in_wd != 5'd0);
                        rw_d      = in_wd;
                        wdata_d   = in_wdata;
                        retired_d = retired_q + 1'b1;
                    end else if (misaligned) begin
                        align_err_d = 1'b1;
                        retired_d   = retired_q + 1'b1;
                    end else begin
                        state_d      = WAIT_LD;
                        pend_valid_d = 1'b1;
                        pend_addr_d  = in_wd;
                        timer_d      = 8'd0;
                        ld_wd_d      = in_wd;
                        ld_wreg_d    = in_wreg;
                        ld_type_d    = in_ld_type;
                        ld_addr_d    = in_addr_lo;
                    end
                end
            end

            WAIT_LD: begin
                timer_d = timer_q + 8'd1;
                if (flush) begin
                    state_d      = IDLE;
                    pend_valid_d = 1'b0;
                    discard_d    = 1'b1;
                end else if (dmem_rvalid && !discard_q) begin
                    state_d      = IDLE;
                    we_d         = ld_wreg_q && (ld_wd_q != 5'd0);
                    rw_d         = ld_wd_q;
                    wdata_d      = ld_value;
                    pend_valid_d = 1'b0;
                    retired_d    = retired_q + 1'b1;
                end else begin
                    // A stale response does not count as ours, so the timeout
                    // can still fire in the same cycle and re-arm discard.
                    if (dmem_rvalid) begin
                        discard_d = 1'b0;
                    end
                    if (timer_q == TIMER_LAST) begin
                        state_d      = IDLE;
                        ld_timeout_d = 1'b1;
                        pend_valid_d = 1'b0;
                        discard_d    = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            rw_q         <= 5'd0;
            wdata_q      <= 32'd0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 5'd0;
            align_err_q  <= 1'b0;
            ld_timeout_q <= 1'b0;
            retired_q    <= '0;
            discard_q    <= 1'b0;
            timer_q      <= 8'd0;
            ld_wd_q      <= 5'd0;
            ld_wreg_q    <= 1'b0;
            ld_type_q    <= 3'd0;
            ld_addr_q    <= 2'd0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            rw_q         <= rw_d;
            wdata_q      <= wdata_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            align_err_q  <= align_err_d;
            ld_timeout_q <= ld_timeout_d;
            retired_q    <= retired_d;
            discard_q    <= discard_d;
            timer_q      <= timer_d;
            ld_wd_q      <= ld_wd_d;
            ld_wreg_q    <= ld_wreg_d;
            ld_type_q    <= ld_type_d;
            ld_addr_q    <= ld_addr_d;
        end
    end

    assign we         = we_q;
    assign rw         = rw_q;
    assign wdata      = wdata_q;
    assign pend_valid = pend_valid_q;
    assign pend_addr  = pend_addr_q;
    assign align_err  = align_err_q;
    assign ld_timeout = ld_timeout_q;
    assign retired    = retired_q;

endmodule
